// File: rtl/ssd1309_spi_sink.sv
// SSD1309 4-wire SPI display-end receiver: oversamples the link, decodes commands and
// writes data bytes into a page/column framebuffer with horizontal addressing.
module ssd1309_spi_sink #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8,
    localparam int unsigned CW         = $clog2(COLS),
    localparam int unsigned PW         = $clog2(PAGES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 oled_rst,
    input  logic                 spi_cs,
    input  logic                 spi_dc,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 fb_we,
    output logic [PW+CW-1:0]     fb_addr,
    output logic [7:0]           fb_wdata,
    output logic                 display_on,
    output logic [7:0]           contrast,
    output logic                 frame_done,
    output logic                 cmd_err
);

    typedef enum logic [1:0] {StIdle, StArg1, StArg2} state_t;

    // Sync vector bit order: {oled_rst, dc, mosi, cs, sclk}; idle levels keep cs/oled_rst high.
    localparam logic [4:0] SyncIdle = 5'b10010;

    logic [SYNC_STAGES-1:0][4:0] sync;
    logic [4:0] synced;
    logic       sclk_prev, cs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= {SYNC_STAGES{SyncIdle}};
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], {oled_rst, spi_dc, spi_mosi, spi_cs, spi_sclk}};
            sclk_prev <= synced[0];
            cs_prev   <= synced[1];
        end
    end

    logic       s_sclk, s_cs, s_mosi, s_dc, s_oled_rst;
    logic       sclk_rise, cs_rise, byte_done, soft_rst;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] rx_byte;

    always_comb begin
        synced     = sync[SYNC_STAGES-1];
        s_sclk     = synced[0];
        s_cs       = synced[1];
        s_mosi     = synced[2];
        s_dc       = synced[3];
        s_oled_rst = synced[4];
        sclk_rise  = s_sclk & ~sclk_prev & ~s_cs;
        cs_rise    = s_cs & ~cs_prev;
        byte_done  = sclk_rise && (bit_cnt == 3'd7);
        rx_byte    = {shift_reg, s_mosi};
        soft_rst   = ~s_oled_rst;
    end

    state_t        state;
    logic [7:0]    opcode;
    logic [CW-1:0] col_start, col_end, col_ptr;
    logic [PW-1:0] page_start, page_end, page_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= 8'h00;
            display_on <= 1'b0;
            contrast   <= 8'h7F;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            state      <= StIdle;
            opcode     <= 8'h00;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            col_start  <= '0;
            col_end    <= CW'(COLS - 1);
            col_ptr    <= '0;
            page_start <= '0;
            page_end   <= PW'(PAGES - 1);
            page_ptr   <= '0;
        end else if (soft_rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= 8'h00;
            display_on <= 1'b0;
            contrast   <= 8'h7F;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            state      <= StIdle;
            opcode     <= 8'h00;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            col_start  <= '0;
            col_end    <= CW'(COLS - 1);
            col_ptr    <= '0;
            page_start <= '0;
            page_end   <= PW'(PAGES - 1);
            page_ptr   <= '0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;

            if (sclk_rise) begin
                shift_reg <= rx_byte[6:0];
                bit_cnt   <= bit_cnt + 3'd1;
            end else if (cs_rise && bit_cnt != 3'd0) begin
                bit_cnt <= 3'd0;
                cmd_err <= 1'b1;
            end

            if (byte_done && s_dc) begin
                state    <= StIdle;
                fb_we    <= 1'b1;
                fb_addr  <= {page_ptr, col_ptr};
                fb_wdata <= rx_byte;
                if (col_ptr == col_end) begin
                    col_ptr <= col_start;
                    if (page_ptr == page_end) begin
                        page_ptr   <= page_start;
                        frame_done <= 1'b1;
                    end else begin
                        page_ptr <= page_ptr + 1'b1;
                    end
                end else begin
                    col_ptr <= col_ptr + 1'b1;
                end
            end else if (byte_done) begin
                unique case (state)
                    StIdle: begin
                        case (rx_byte)
                            8'hAE: display_on <= 1'b0;
                            8'hAF: display_on <= 1'b1;
                            8'hD5, 8'h20, 8'h81, 8'h21, 8'h22: begin
                                opcode <= rx_byte;
                                state  <= StArg1;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                    StArg1: begin
                        state <= StIdle;
                        case (opcode)
                            8'h81: contrast <= rx_byte;
                            8'h20: if (rx_byte != 8'h00) cmd_err <= 1'b1;
                            8'h21: begin
                                col_start <= rx_byte[CW-1:0];
                                state     <= StArg2;
                            end
                            8'h22: begin
                                page_start <= rx_byte[PW-1:0];
                                state      <= StArg2;
                            end
                            // Oscillator setting (0xD5) has no effect on this model.
                            default: ;
                        endcase
                    end
                    StArg2: begin
                        state    <= StIdle;
                        col_ptr  <= col_start;
                        page_ptr <= page_start;
                        if (opcode == 8'h21) begin
                            col_end <= rx_byte[CW-1:0];
                        end else begin
                            page_end <= rx_byte[PW-1:0];
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
